// File: rtl/j4_io_hub_pkg.sv
// Shared constants, access decode and status packing for the j4 I/O hub.
package j4_io_hub_pkg;

  localparam int NUM_SLOTS = 4;

  localparam logic [15:0] IO_SLOT_ID   = 16'h0100;
  localparam logic [15:0] IO_TICK_LO   = 16'h0101;
  localparam logic [15:0] IO_TICK_HI   = 16'h0102;
  localparam logic [15:0] IO_MBOX      = 16'h0110;
  localparam logic [15:0] IO_MBOX_STAT = 16'h0114;
  localparam logic [15:0] IO_KILL      = 16'h0120;

  // One-hot-ish view of the current bus access; at most one field is set.
  typedef struct packed {
    logic rd_slot_id;
    logic rd_tick_lo;
    logic rd_tick_hi;
    logic rd_pop;
    logic rd_stat;
    logic wr_push;
    logic wr_clr;
    logic wr_kill;
  } io_dec_t;

  function automatic io_dec_t io_decode(input logic rd, input logic wr,
                                        input logic [15:0] addr);
    io_dec_t d;
    d = '0;
    d.rd_slot_id = rd && (addr == IO_SLOT_ID);
    d.rd_tick_lo = rd && (addr == IO_TICK_LO);
    d.rd_tick_hi = rd && (addr == IO_TICK_HI);
    d.rd_pop     = rd && (addr == IO_MBOX);
    d.rd_stat    = rd && (addr == IO_MBOX_STAT);
    // Push window covers 0x0110..0x0113, low two bits select the target slot.
    d.wr_push    = wr && (addr[15:2] == IO_MBOX[15:2]);
    d.wr_clr     = wr && (addr == IO_MBOX_STAT);
    d.wr_kill    = wr && (addr == IO_KILL);
    return d;
  endfunction

  function automatic logic [15:0] mbox_stat(input logic ovf, input logic unf,
                                            input logic [4:0] cnt);
    return {8'h00, ovf, unf, 1'b0, cnt};
  endfunction

endpackage

// File: rtl/j4_io_hub_if.sv
// Core-side I/O bus between the j4 barrel core and the hub.
interface j4_io_hub_if;
  logic        io_rd;
  logic        io_wr;
  logic [15:0] mem_addr;
  logic [15:0] dout;
  logic [1:0]  io_slot;
  logic [15:0] io_din;
  logic [3:0]  kill_slot_rq;

  // Core side drives the access, receives read data and kill requests.
  modport master (output io_rd, io_wr, mem_addr, dout, io_slot,
                  input  io_din, kill_slot_rq);
  // Hub side responds.
  modport slave  (input  io_rd, io_wr, mem_addr, dout, io_slot,
                  output io_din, kill_slot_rq);
endinterface

// File: rtl/j4_io_hub_mbox_fifo.sv
// Per-slot mailbox FIFO: register array, combinational head, flush wins over push/pop.
module j4_mbox_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          resetq,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [15:0]   wd,
  output logic [15:0]   rd,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [DEPTH-1:0][15:0] mem;
  logic [AW-1:0]          wp;
  logic [AW-1:0]          rp;
  logic                   do_push;
  logic                   do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd      = mem[rp];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer/count/storage update; pointers wrap naturally at 2**AW.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      mem   <= '0;
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= wd;
        wp      <= wp + 1'b1;
      end
      if (do_pop) rp <= rp + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/j4_io_hub.sv
// Slot-aware I/O responder: per-slot mailboxes, cycle counter with
// coherent hi-half shadow, and slot-kill pulse register.
module j4_io_hub
  import j4_io_hub_pkg::*;
#(
  parameter int MBOX_DEPTH = 4,
  parameter int MBOX_AW    = 2
) (
  input  logic        clk,
  input  logic        resetq,
  j4_io_hub_if.slave  bus
);

  io_dec_t dec;
  assign dec = io_decode(bus.io_rd, bus.io_wr, bus.mem_addr);

  logic [31:0]                          tick;
  logic [NUM_SLOTS-1:0][15:0]           tick_hi_shadow;
  logic [NUM_SLOTS-1:0]                 ovf;
  logic [NUM_SLOTS-1:0]                 unf;
  logic [3:0]                           kill_q;

  logic [NUM_SLOTS-1:0]                 push;
  logic [NUM_SLOTS-1:0]                 pop;
  logic [NUM_SLOTS-1:0]                 flush;
  logic [NUM_SLOTS-1:0]                 clr_flags;
  logic [NUM_SLOTS-1:0]                 full;
  logic [NUM_SLOTS-1:0]                 empty;
  logic [NUM_SLOTS-1:0][15:0]           mb_rd;
  logic [NUM_SLOTS-1:0][MBOX_AW:0]      mb_count;
  logic [15:0]                          din;

  // Per-slot strobes; a kill pulse flushes its slot's mailbox on the pulse cycle.
  always_comb begin
    push      = '0;
    pop       = '0;
    flush     = '0;
    clr_flags = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      push[s]      = dec.wr_push && (bus.mem_addr[1:0] == 2'(s));
      pop[s]       = dec.rd_pop  && (bus.io_slot == 2'(s));
      clr_flags[s] = dec.wr_clr  && bus.dout[0] && (bus.io_slot == 2'(s));
      flush[s]     = kill_q[s] ||
                     (dec.wr_clr && bus.dout[1] && (bus.io_slot == 2'(s)));
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_mbox
    j4_mbox_fifo #(.DEPTH(MBOX_DEPTH), .AW(MBOX_AW)) u_fifo (
      .clk    (clk),
      .resetq (resetq),
      .push   (push[g]),
      .pop    (pop[g]),
      .flush  (flush[g]),
      .wd     (bus.dout),
      .rd     (mb_rd[g]),
      .count  (mb_count[g]),
      .full   (full[g]),
      .empty  (empty[g])
    );
  end

  // Free-running cycle counter.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) tick <= '0;
    else         tick <= tick + 32'd1;
  end

  // Hi-half shadow capture on LO read, and sticky over/underflow flags.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      tick_hi_shadow <= '0;
      ovf            <= '0;
      unf            <= '0;
    end else begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (dec.rd_tick_lo && (bus.io_slot == 2'(s)))
          tick_hi_shadow[s] <= tick[31:16];
        if (clr_flags[s]) begin
          ovf[s] <= 1'b0;
          unf[s] <= 1'b0;
        end else begin
          if (push[s] && full[s] && !flush[s]) ovf[s] <= 1'b1;
          if (pop[s] && empty[s])              unf[s] <= 1'b1;
        end
      end
    end
  end

  // Kill register: one-cycle pulse per KILL write, back-to-back writes chain.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) kill_q <= '0;
    else         kill_q <= dec.wr_kill ? bus.dout[3:0] : 4'h0;
  end

  assign bus.kill_slot_rq = kill_q;

  // Read mux; zero when no read, unmapped, popping empty, or held in reset.
  always_comb begin
    din = '0;
    if (dec.rd_slot_id)      din = {14'b0, bus.io_slot};
    else if (dec.rd_tick_lo) din = tick[15:0];
    else if (dec.rd_tick_hi) din = tick_hi_shadow[bus.io_slot];
    else if (dec.rd_pop)     din = empty[bus.io_slot] ? 16'h0000 : mb_rd[bus.io_slot];
    else if (dec.rd_stat)    din = mbox_stat(ovf[bus.io_slot], unf[bus.io_slot],
                                             5'(mb_count[bus.io_slot]));
    if (!resetq) din = '0;
  end

  assign bus.io_din = din;

endmodule
